// File: rtl/ddr_clear_seq.sv
// Burst-write sequencer that fills a DDR3 region with a fixed or address-tagged
// pattern through the DDRAM Avalon-style write port.
module ddr_clear_seq #(
    parameter logic [28:0] BASE_ADDR = 29'h0000000,
    parameter logic [29:0] WORDS     = 30'd4194304,
    parameter int unsigned BURST     = 8,
    parameter logic [63:0] PATTERN   = 64'h0,
    parameter bit          ADDR_DATA = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    output logic        DDRAM_RD
);

    localparam int unsigned AW = 29;
    localparam int unsigned RW = 30;
    localparam int unsigned CW = 8;
    localparam int unsigned DW = 64;

    localparam logic [DW-1:0] DIN_RST = ADDR_DATA ? '0 : PATTERN;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [RW-1:0] remaining_q, remaining_d;
    logic [CW-1:0] beat_cnt_q,  beat_cnt_d;
    logic [AW-1:0] beat_addr_q, beat_addr_d;

    logic          we_d;
    logic [CW-1:0] burstcnt_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] din_d;
    logic          busy_d;
    logic          done_d;

    logic accept;
    logic last_beat;
    logic last_word;

    // Beat count of a burst: whatever is left, capped at BURST.
    function automatic logic [CW-1:0] burst_len(input logic [RW-1:0] rem);
        return (rem < RW'(BURST)) ? CW'(rem) : CW'(BURST);
    endfunction

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
        return ADDR_DATA ? {35'b0, a} : PATTERN;
    endfunction

    assign accept    = DDRAM_WE && !DDRAM_BUSY;
    assign last_beat = accept && (beat_cnt_q == CW'(1));
    assign last_word = (remaining_q == RW'(1));

    assign DDRAM_BE = 8'hFF;
    assign DDRAM_RD = 1'b0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (WORDS == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_beat) begin
                    state_d = last_word ? S_DONE : S_GAP;
                end
            end
            S_GAP:   state_d = S_WRITE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered bus outputs and the fill counters.
    always_comb begin
        we_d        = DDRAM_WE;
        burstcnt_d  = DDRAM_BURSTCNT;
        addr_d      = DDRAM_ADDR;
        din_d       = DDRAM_DIN;
        busy_d      = busy;
        done_d      = done;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        beat_addr_d = beat_addr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d = (WORDS == '0);
                    if (WORDS != '0) begin
                        busy_d      = 1'b1;
                        we_d        = 1'b1;
                        burstcnt_d  = burst_len(WORDS);
                        beat_cnt_d  = burst_len(WORDS);
                        addr_d      = BASE_ADDR;
                        beat_addr_d = BASE_ADDR;
                        remaining_d = WORDS;
                        din_d       = beat_data(BASE_ADDR);
                    end
                end
            end
            S_WRITE: begin
                if (accept) begin
                    beat_cnt_d  = beat_cnt_q - CW'(1);
                    remaining_d = remaining_q - RW'(1);
                    beat_addr_d = beat_addr_q + AW'(1);
                    din_d       = beat_data(beat_addr_q + AW'(1));
                    if (last_beat) begin
                        we_d = 1'b0;
                        if (last_word) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                // Next burst starts where the data address has advanced to.
                we_d       = 1'b1;
                burstcnt_d = burst_len(remaining_q);
                beat_cnt_d = burst_len(remaining_q);
                addr_d     = beat_addr_q;
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            DDRAM_WE       <= 1'b0;
            DDRAM_BURSTCNT <= '0;
            DDRAM_ADDR     <= '0;
            DDRAM_DIN      <= DIN_RST;
            busy           <= 1'b0;
            done           <= 1'b0;
            remaining_q    <= '0;
            beat_cnt_q     <= '0;
            beat_addr_q    <= '0;
        end else begin
            DDRAM_WE       <= we_d;
            DDRAM_BURSTCNT <= burstcnt_d;
            DDRAM_ADDR     <= addr_d;
            DDRAM_DIN      <= din_d;
            busy           <= busy_d;
            done           <= done_d;
            remaining_q    <= remaining_d;
            beat_cnt_q     <= beat_cnt_d;
            beat_addr_q    <= beat_addr_d;
        end
    end

endmodule
